fs_cap_mc: RTL and testbench



---
 rtl/fs_cap_mc_if.sv | 16 +
 rtl/fs_cap_mc.sv | 144 ++++++++++++++
 tb/tb_fs_cap_mc.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fs_cap_mc_if.sv
// Sync-capture bus: raw sync/ready/mode/clear in, filtered level and event flags out.
interface fs_cap_mc_if #(parameter int CH_NUM = 4);
  logic [CH_NUM-1:0]   fs_i;
  logic [CH_NUM-1:0]   rdy_i;
  logic [2*CH_NUM-1:0] edge_sel_i;
  logic [CH_NUM-1:0]   clr_i;
  logic [CH_NUM-1:0]   lvl_o;
  logic [CH_NUM-1:0]   fs_o;
  logic [CH_NUM-1:0]   lost_o;
  logic [CH_NUM-1:0]   to_o;

  modport master (output fs_i, rdy_i, edge_sel_i, clr_i,
                  input  lvl_o, fs_o, lost_o, to_o);
  modport slave  (input  fs_i, rdy_i, edge_sel_i, clr_i,
                  output lvl_o, fs_o, lost_o, to_o);
endinterface

// File: rtl/fs_cap_mc.sv
// Multi-channel frame/field sync capture: synchronise, persistence-filter,
// edge-detect and flag accepted/lost events plus sync-loss timeout per channel.
module fs_cap_lane #(
  parameter int   SYNC_STAGES = 4,
  parameter int   FILT_LEN    = 21,
  parameter logic RST_V       = 1'b1,
  parameter int   TO_W        = 24
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       fs_i,
  input  logic       rdy_i,
  input  logic [1:0] edge_sel_i,
  input  logic       clr_i,
  output logic       lvl_o,
  output logic       fs_o,
  output logic       lost_o,
  output logic       to_o
);
  localparam int             CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILT_LEN - 1);
  localparam logic [TO_W-1:0] TMR_MAX = '1;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   dly_q, dly_d;
  logic                   fs_q, fs_d;
  logic                   lost_q, lost_d;
  logic [TO_W-1:0]        tmr_q, tmr_d;
  logic                   s, rise, fall, det;
  edge_mode_e             mode;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], fs_i};
    s      = sync_q[SYNC_STAGES-1];
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    // Any return to the current level restarts the persistence count.
    if (s == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      lvl_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    dly_d = lvl_q;
    rise  = lvl_q & ~dly_q;
    fall  = ~lvl_q & dly_q;
    mode  = edge_mode_e'(edge_sel_i);
    det   = 1'b0;
    case (mode)
      EDGE_RISE: det = rise;
      EDGE_FALL: det = fall;
      EDGE_BOTH: det = rise | fall;
      EDGE_OFF:  det = 1'b0;
      default:   det = 1'b0;
    endcase

    fs_d   = det & rdy_i;
    // A new lost event outranks a same-cycle clear.
    lost_d = (det & ~rdy_i) | (lost_q & ~clr_i);

    if (det)                 tmr_d = '0;
    else if (tmr_q == TMR_MAX) tmr_d = tmr_q;
    else                     tmr_d = tmr_q + TO_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_V}};
      cnt_q  <= '0;
      lvl_q  <= RST_V;
      dly_q  <= RST_V;
      fs_q   <= 1'b0;
      lost_q <= 1'b0;
      tmr_q  <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      dly_q  <= dly_d;
      fs_q   <= fs_d;
      lost_q <= lost_d;
      tmr_q  <= tmr_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign fs_o   = fs_q;
  assign lost_o = lost_q;
  assign to_o   = (tmr_q == TMR_MAX);
endmodule

module fs_cap_mc #(
  parameter int              CH_NUM      = 4,
  parameter int              SYNC_STAGES = 4,
  parameter int              FILT_LEN    = 21,
  parameter logic [CH_NUM-1:0] RST_LVL   = {CH_NUM{1'b1}},
  parameter int              TO_W        = 24
) (
  input  logic        clk_i,
  input  logic        rst_i,
  fs_cap_mc_if.slave  bus
);
  logic [CH_NUM-1:0][1:0] sel;
  logic [CH_NUM-1:0]      lvl, fs, lost, to;

  assign sel = bus.edge_sel_i;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
    fs_cap_lane #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .RST_V       (RST_LVL[g]),
      .TO_W        (TO_W)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .fs_i       (bus.fs_i[g]),
      .rdy_i      (bus.rdy_i[g]),
      .edge_sel_i (sel[g]),
      .clr_i      (bus.clr_i[g]),
      .lvl_o      (lvl[g]),
      .fs_o       (fs[g]),
      .lost_o     (lost[g]),
      .to_o       (to[g])
    );
  end

  assign bus.lvl_o  = lvl;
  assign bus.fs_o   = fs;
  assign bus.lost_o = lost;
  assign bus.to_o   = to;
endmodule

// File: tb/tb_fs_cap_mc.sv
// Bench for fs_cap_mc: cycle reference model feeds an expected-pulse queue,
// a monitor checks pulses and flags; directed steps plus a random phase.
module tb_fs_cap_mc;
  localparam int CH = 4, SS = 4, FL = 21, TW = 8;
  localparam logic [CH-1:0] RL = '1;
  localparam int TMAX = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fs_cap_mc_if #(.CH_NUM(CH)) bus();

  fs_cap_mc #(.CH_NUM(CH), .SYNC_STAGES(SS), .FILT_LEN(FL), .RST_LVL(RL), .TO_W(TW))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  typedef struct { int ch; int cyc; } ev_t;
  ev_t exp_q[$];

  int nvec = 0, nerr = 0;
  int cyc = 0;
  int rel = 0;
  bit to_chk = 1'b0;
  int pulse_cnt [CH];

  // reference model state
  logic [CH-1:0] in_hist[$];
  bit m_lvl [CH], m_prev [CH], m_lost [CH];
  int m_run [CH], m_tmr [CH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: delay line of raw samples, run-length persistence, then event rules.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      in_hist.delete();
      repeat (SS) in_hist.push_back(RL);
      exp_q.delete();
      for (int c = 0; c < CH; c++) begin
        m_lvl[c] = RL[c]; m_prev[c] = RL[c]; m_lost[c] = 1'b0;
        m_run[c] = 0; m_tmr[c] = 0;
      end
    end else begin
      logic [CH-1:0] s_vec;
      s_vec = in_hist[0];
      for (int c = 0; c < CH; c++) begin
        bit det;
        logic [1:0] md;
        md = bus.edge_sel_i[2*c +: 2];
        case (md)
          2'd0: det = m_lvl[c] && !m_prev[c];
          2'd1: det = !m_lvl[c] && m_prev[c];
          2'd2: det = m_lvl[c] != m_prev[c];
          default: det = 1'b0;
        endcase
        m_prev[c] = m_lvl[c];
        if (s_vec[c] == m_lvl[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == FL) begin m_lvl[c] = s_vec[c]; m_run[c] = 0; end
        end
        if (det && bus.rdy_i[c]) exp_q.push_back('{c, cyc});
        if (det && !bus.rdy_i[c]) m_lost[c] = 1'b1;
        else if (bus.clr_i[c]) m_lost[c] = 1'b0;
        if (det) m_tmr[c] = 0;
        else if (m_tmr[c] < TMAX) m_tmr[c]++;
      end
      in_hist.push_back(bus.fs_i);
      void'(in_hist.pop_front());
    end
  end

  // Monitor: pops the pulse scoreboard and checks flags each cycle.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_pulse", 32'(exp_q[0].ch), 32'hFFFF);
        void'(exp_q.pop_front());
      end
      for (int c = 0; c < CH; c++) begin
        bit e;
        e = exp_q.size() > 0 && exp_q[0].ch == c && exp_q[0].cyc == cyc;
        chk($sformatf("fs_o[%0d]", c), 32'(bus.fs_o[c]), 32'(e));
        if (e) void'(exp_q.pop_front());
        if (bus.fs_o[c]) pulse_cnt[c]++;
        chk($sformatf("lvl_o[%0d]", c), 32'(bus.lvl_o[c]), 32'(m_lvl[c]));
        chk($sformatf("lost_o[%0d]", c), 32'(bus.lost_o[c]), 32'(m_lost[c]));
        chk($sformatf("to_o[%0d]", c), 32'(bus.to_o[c]), 32'(m_tmr[c] == TMAX));
      end
      if (to_chk && cyc == rel + 254) chk("to3_before", 32'(bus.to_o[3]), 0);
      if (to_chk && cyc == rel + 255) chk("to3_at_255", 32'(bus.to_o[3]), 1);
    end
  end

  initial begin
    int c0, lc, pc, p;
    int dur [CH];
    int mexp [4] = '{2, 2, 4, 0};
    int others [CH];
    for (int c = 0; c < CH; c++) pulse_cnt[c] = 0;
    rst = 1'b1;
    bus.fs_i = '1; bus.rdy_i = '1; bus.edge_sel_i = '0; bus.clr_i = '0;
    tick(3);
    rst = 1'b0; rel = cyc; to_chk = 1'b1;

    // reset / idle
    tick(100);
    chk("idle_lvl", 32'(bus.lvl_o), 32'hF);
    chk("idle_fs_cnt", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 0);

    // glitch reject on ch0
    bus.fs_i[0] = 1'b0; tick(60);
    p = pulse_cnt[0];
    bus.fs_i[0] = 1'b1; tick(20); bus.fs_i[0] = 1'b0; tick(60);
    chk("glitch20_lvl", 32'(bus.lvl_o[0]), 0);
    chk("glitch20_pulses", 32'(pulse_cnt[0] - p), 0);
    bus.fs_i[0] = 1'b1; tick(21); bus.fs_i[0] = 1'b0; tick(60);
    chk("pulse21_pulses", 32'(pulse_cnt[0] - p), 1);

    // latency on ch0
    bus.fs_i[0] = 1'b1; c0 = cyc; lc = -1; pc = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (lc < 0 && bus.lvl_o[0]) lc = cyc - c0;
      if (pc < 0 && bus.fs_o[0]) pc = cyc - c0;
    end
    chk("lat_lvl", 32'(lc), 25);
    chk("lat_fs", 32'(pc), 26);

    // lost / clear on ch1
    bus.fs_i[1] = 1'b0; tick(40);
    p = pulse_cnt[1];
    bus.rdy_i[1] = 1'b0; bus.fs_i[1] = 1'b1; tick(40);
    chk("lost_set", 32'(bus.lost_o[1]), 1);
    chk("lost_no_pulse", 32'(pulse_cnt[1] - p), 0);
    bus.clr_i[1] = 1'b1; tick(1); bus.clr_i[1] = 1'b0; tick(2);
    chk("lost_clr", 32'(bus.lost_o[1]), 0);
    bus.fs_i[1] = 1'b0; tick(40);
    bus.fs_i[1] = 1'b1; tick(25);
    bus.clr_i[1] = 1'b1; tick(1); bus.clr_i[1] = 1'b0; tick(2);
    chk("lost_set_wins", 32'(bus.lost_o[1]), 1);
    bus.clr_i[1] = 1'b1; tick(1); bus.clr_i[1] = 1'b0; bus.rdy_i[1] = 1'b1; tick(2);

    // edge modes on ch2
    for (int m = 0; m < 4; m++) begin
      bus.edge_sel_i[5:4] = 2'(m);
      p = pulse_cnt[2];
      for (int c = 0; c < CH; c++) others[c] = pulse_cnt[c];
      repeat (4) begin bus.fs_i[2] = ~bus.fs_i[2]; tick(40); end
      chk($sformatf("mode%0d_pulses", m), 32'(pulse_cnt[2] - p), 32'(mexp[m]));
      chk($sformatf("mode%0d_others", m),
          32'(pulse_cnt[0] - others[0] + pulse_cnt[1] - others[1] + pulse_cnt[3] - others[3]), 0);
    end
    bus.edge_sel_i = '0;

    // timeout on ch3 clears after next detected edge
    chk("to3_saturated", 32'(bus.to_o[3]), 1);
    bus.edge_sel_i[7:6] = 2'b10;
    bus.fs_i[3] = 1'b0; tick(25);
    chk("to3_before_edge", 32'(bus.to_o[3]), 1);
    tick(1);
    chk("to3_after_edge", 32'(bus.to_o[3]), 0);

    // reset mid-filter-count on ch0
    tick(40);
    bus.fs_i[0] = 1'b0; tick(13);
    rst = 1'b1; #1;
    chk("rst_lvl", 32'(bus.lvl_o), 32'hF);
    chk("rst_flags", 32'({bus.fs_o, bus.lost_o, bus.to_o}), 0);
    bus.fs_i = '1; bus.edge_sel_i = '0;
    tick(2); rst = 1'b0;
    p = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
    tick(60);
    chk("rst_no_pulse", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3] - p), 0);

    // random phase
    for (int c = 0; c < CH; c++) dur[c] = $urandom_range(1, 50);
    repeat (4000) begin
      for (int c = 0; c < CH; c++) begin
        dur[c]--;
        if (dur[c] == 0) begin
          bus.fs_i[c] = ~bus.fs_i[c];
          dur[c] = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : $urandom_range(18, 90);
        end
        bus.rdy_i[c] = ($urandom_range(0, 99) < 80);
        bus.clr_i[c] = ($urandom_range(0, 99) < 5);
        if ($urandom_range(0, 99) == 0) bus.edge_sel_i[2*c +: 2] = 2'($urandom_range(0, 3));
      end
      tick(1);
    end
    bus.clr_i = '0;
    tick(60);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
